seg7_4digit_to_bcd: RTL

Receive-side counterpart of the 4-digit multiplexed 7-segment driver: watches the scanned `seg`/`an` bus and reconstructs the four hex digits being displayed. It filters scan transitions and decodes each stable segment pattern to a nibble. It collects the digits into per-position registers and flags complete frames. It sits on-chip beside `BCD_to_7seg_4digit`, on the same clock, as a loopback checker and display-readback path.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seg7_4digit_to_bcd.sv | 110 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared active-low 7-segment pattern table and scan helpers
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_NONE   = 4'b1111;

    typedef enum logic [1:0] {
        CAP_IGNORE = 2'd0,
        CAP_DIGIT  = 2'd1,
        CAP_ERROR  = 2'd2
    } cap_kind_e;

    // Classifies an active-low anode vector: blank, exactly one digit, or overlap.
    function automatic cap_kind_e an_classify(input logic [3:0] an);
        logic [3:0] low;
        low = ~an;
        if (low == 4'b0000)
            return CAP_IGNORE;
        else if ((low & (low - 4'd1)) == 4'b0000)
            return CAP_DIGIT;
        else
            return CAP_ERROR;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!an[i])
                idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational active-low segment pattern to nibble lookup
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       legal
);

    always_comb begin
        hex   = 4'h0;
        legal = 1'b1;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_4digit_to_bcd.sv
// rtl/seg7_4digit_to_bcd.sv - reconstructs four hex digits from a scanned 7-segment bus
module seg7_4digit_to_bcd
    import seg7_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] out3,
    output logic [3:0] out2,
    output logic [3:0] out1,
    output logic [3:0] out0,
    output logic       valid,
    output logic       frame,
    output logic       err
);

    localparam logic [10:0] IN_RESET = {AN_NONE, SEG_BLANK};
    localparam logic [7:0]  CNT_MAX  = 8'(SETTLE);
    localparam logic [7:0]  CNT_FIRE = 8'(SETTLE - 1);

    logic [10:0] in_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt;
    logic [3:0]  digit_q [4];
    logic [3:0]  seen;

    logic [3:0]  dec_hex;
    logic        dec_legal;
    logic        stable;
    logic        strobe;
    cap_kind_e   kind;
    logic [1:0]  idx;
    logic        do_write;
    logic        do_err;
    logic [3:0]  seen_set;

    seg7_pattern_decode u_decode (
        .seg   (in_q[6:0]),
        .hex   (dec_hex),
        .legal (dec_legal)
    );

    assign stable = (in_q == prev_q);
    // The count only sits at SETTLE-1 for one cycle before saturating, so this fires once per hold.
    assign strobe = stable && (cnt == CNT_FIRE);

    always_comb begin
        kind     = an_classify(in_q[10:7]);
        idx      = an_index(in_q[10:7]);
        do_write = 1'b0;
        do_err   = 1'b0;
        seen_set = seen;
        if (strobe) begin
            case (kind)
                CAP_DIGIT: begin
                    if (dec_legal) begin
                        do_write      = 1'b1;
                        seen_set[idx] = 1'b1;
                    end else begin
                        do_err = 1'b1;
                    end
                end
                CAP_ERROR: do_err = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= IN_RESET;
            prev_q <= IN_RESET;
            cnt    <= 8'd0;
            seen   <= 4'b0000;
            valid  <= 1'b0;
            frame  <= 1'b0;
            err    <= 1'b0;
            for (int i = 0; i < 4; i++)
                digit_q[i] <= 4'h0;
        end else begin
            in_q   <= {an, seg};
            prev_q <= in_q;
            frame  <= 1'b0;
            err    <= do_err;
            if (!stable)
                cnt <= 8'd0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
            if (do_write) begin
                digit_q[idx] <= dec_hex;
                if (seen_set == 4'b1111) begin
                    frame <= 1'b1;
                    valid <= 1'b1;
                    seen  <= 4'b0000;
                end else begin
                    seen <= seen_set;
                end
            end
        end
    end

    assign out0 = digit_q[0];
    assign out1 = digit_q[1];
    assign out2 = digit_q[2];
    assign out3 = digit_q[3];

endmodule
